squash_shift: RTL

Downstream stage of the XOR-squash reduction. It accepts one registered SQUASH_WIDTH-bit squash result per handshake and shifts it into a 128-bit state held as two 64-bit halves. After a full frame of bytes, it presents the halves to the next stage with a valid/ready handshake. The input side is back-pressured while a completed frame is waiting to be taken.

---
 rtl/squash_pkg.sv | 20 ++
 rtl/squash_shift_reg.sv | 36 +++
 rtl/squash_shift.sv | 108 ++++++++++
 3 files changed

// File: rtl/squash_pkg.sv
`default_nettype none
// ============================================================================
// Package  : squash_pkg
// Shared widths, frame constants and FSM state type for the XOR-squash chain.
// Revision : 1.0 - initial release
// ============================================================================
package squash_pkg;

    localparam int c_TOTAL_WIDTH  = 128;
    localparam int c_SQUASH_WIDTH = 8;
    localparam int c_FRAME_LEN    = c_TOTAL_WIDTH / c_SQUASH_WIDTH;
    localparam int c_CNT_WIDTH    = $clog2(c_FRAME_LEN + 1);

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } squash_state_t;

endpackage : squash_pkg
`default_nettype wire

// File: rtl/squash_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : squash_shift_reg
// TOTAL_WIDTH-bit shift register, SQUASH_WIDTH bits in per enabled cycle.
// Revision : 1.0 - initial release
// ============================================================================
module squash_shift_reg
    import squash_pkg::*;
#(
    parameter int TOTAL_WIDTH  = c_TOTAL_WIDTH,
    parameter int SQUASH_WIDTH = c_SQUASH_WIDTH
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     shift_en_i,
    input  logic [SQUASH_WIDTH-1:0]  data_i,
    output logic [TOTAL_WIDTH/2-1:0] hi_o,
    output logic [TOTAL_WIDTH/2-1:0] lo_o
);

    logic [TOTAL_WIDTH-1:0] r_shift;

    // The oldest byte falls off the top of hi; lo's top byte crosses into hi.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_shift <= '0;
        end else if (shift_en_i) begin
            r_shift <= {r_shift[TOTAL_WIDTH-SQUASH_WIDTH-1:0], data_i};
        end
    end

    assign hi_o = r_shift[TOTAL_WIDTH-1:TOTAL_WIDTH/2];
    assign lo_o = r_shift[TOTAL_WIDTH/2-1:0];

endmodule : squash_shift_reg
`default_nettype wire

// File: rtl/squash_shift.sv
`default_nettype none
// ============================================================================
// Module   : squash_shift
// Collects squash results into a 128-bit frame, presented via valid/ready.
// Optional partial-frame close: define SQUASH_SHIFT_FLUSH_EN.
// Revision : 1.0 - initial release
// ============================================================================
module squash_shift
    import squash_pkg::*;
#(
    parameter int TOTAL_WIDTH  = c_TOTAL_WIDTH,
    parameter int SQUASH_WIDTH = c_SQUASH_WIDTH,
    parameter int FRAME_LEN    = TOTAL_WIDTH / SQUASH_WIDTH,
    parameter int LEN_W        = $clog2(FRAME_LEN + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     sq_valid_i,
    input  logic [SQUASH_WIDTH-1:0]  sq_data_i,
    output logic                     sq_ready_o,
    output logic [TOTAL_WIDTH/2-1:0] hi_o,
    output logic [TOTAL_WIDTH/2-1:0] lo_o,
    output logic                     frame_valid_o,
`ifdef SQUASH_SHIFT_FLUSH_EN
    input  logic                     flush_i,
`endif
    input  logic                     frame_ready_i,
    output logic [LEN_W-1:0]         frame_len_o
);

    squash_state_t    r_state;
    logic [LEN_W-1:0] r_cnt;
    logic             r_sq_ready;
    logic             r_frame_valid;
    logic [LEN_W-1:0] r_frame_len;

    logic             w_accept;
    logic             w_last;
    logic             w_flush;
    logic             w_close;
    logic [LEN_W-1:0] w_fill_len;

    // Ready is only ever high in FILL, so an accept implies FILL.
    assign w_accept   = sq_valid_i & r_sq_ready;
    assign w_last     = (r_cnt == LEN_W'(FRAME_LEN - 1));
    assign w_fill_len = r_cnt + {{(LEN_W-1){1'b0}}, w_accept};

`ifdef SQUASH_SHIFT_FLUSH_EN
    assign w_flush = flush_i && (r_state == FILL) && ((r_cnt != '0) || w_accept);
`else
    assign w_flush = 1'b0;
`endif

    assign w_close = (w_accept & w_last) | w_flush;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state       <= FILL;
            r_cnt         <= '0;
            r_sq_ready    <= 1'b1;
            r_frame_valid <= 1'b0;
            r_frame_len   <= '0;
        end else begin
            case (r_state)
                FILL: begin
                    if (w_close) begin
                        r_state       <= HOLD;
                        r_sq_ready    <= 1'b0;
                        r_frame_valid <= 1'b1;
                        r_frame_len   <= w_fill_len;
                        r_cnt         <= '0;
                    end else if (w_accept) begin
                        r_cnt <= r_cnt + LEN_W'(1);
                    end
                end
                HOLD: begin
                    if (frame_ready_i && r_frame_valid) begin
                        r_state       <= FILL;
                        r_sq_ready    <= 1'b1;
                        r_frame_valid <= 1'b0;
                        r_frame_len   <= '0;
                    end
                end
                default: begin
                    r_state <= FILL;
                end
            endcase
        end
    end

    squash_shift_reg #(
        .TOTAL_WIDTH  (TOTAL_WIDTH),
        .SQUASH_WIDTH (SQUASH_WIDTH)
    ) u_shift_reg (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .shift_en_i (w_accept),
        .data_i     (sq_data_i),
        .hi_o       (hi_o),
        .lo_o       (lo_o)
    );

    assign sq_ready_o    = r_sq_ready;
    assign frame_valid_o = r_frame_valid;
    assign frame_len_o   = r_frame_len;

endmodule : squash_shift
`default_nettype wire
